// File: rtl/fpu_add_sub_normalizer_pkg.sv
// Shared FP16 constants and types for the add/sub normalizer slice.
//   fp16_t        : packed half-precision {sign, exp[4:0], frac[9:0]}
//   EXP_MAX       : all-ones exponent (infinity encoding)
//   RAW_MANT_W    : raw adder mantissa {carry, hidden, frac[9:0], G, R, S}
//   MAX_LSHIFT    : left-shift budget per operation
//   norm_state_e  : normalizer FSM states
package fpu_add_sub_normalizer_pkg;

  localparam int unsigned FP16_EXP_W  = 5;
  localparam int unsigned FP16_FRAC_W = 10;
  localparam int unsigned RAW_MANT_W  = 15;
  localparam int unsigned MAX_LSHIFT  = 11;

  localparam logic [FP16_EXP_W-1:0] EXP_MAX = 5'd31;

  typedef struct packed {
    logic                   sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_FRAC_W-1:0] frac;
  } fp16_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_DONE
  } norm_state_e;

endpackage

// File: rtl/fpuRounder.sv
// Combinational rounder for the normalizer.
// Macro: FPU_NORM_ROUND_EN selects round-to-nearest-even; otherwise truncate.
// Ports:
//   mant_in  : {hidden, frac[9:0]} before rounding
//   grs      : guard, round, sticky bits
//   mant_out : {hidden, frac[9:0]} after rounding
//   carry    : increment rippled out above the hidden position
module fpuRounder
  import fpu_add_sub_normalizer_pkg::*;
(
  input  logic [FP16_FRAC_W:0] mant_in,
  input  logic [2:0]           grs,
  output logic [FP16_FRAC_W:0] mant_out,
  output logic                 carry
);

`ifdef FPU_NORM_ROUND_EN
  logic                 round_up;
  logic [FP16_FRAC_W+1:0] sum;

  // Round up above half, or on an exact tie when the LSB is odd.
  assign round_up = grs[2] & (grs[1] | grs[0] | mant_in[0]);
  assign sum      = {1'b0, mant_in} + {{(FP16_FRAC_W+1){1'b0}}, round_up};
  assign mant_out = sum[FP16_FRAC_W:0];
  assign carry    = sum[FP16_FRAC_W+1];
`else
  logic grs_unused;

  assign grs_unused = ^grs;
  assign mant_out   = mant_in;
  assign carry      = 1'b0;
`endif

endmodule

// File: rtl/fpu_add_sub_normalizer.sv
// FP16 add/sub post-normalizer: takes the raw adder result, normalizes it
// (one right shift on carry-out, or up to MAX_LSHIFT left shifts), rounds
// and packs it into fp16_t, then holds it until the consumer accepts.
// Macro: FPU_NORM_ROUND_EN enables round-to-nearest-even (default truncate).
// Ports:
//   clock, reset_n      : clock, asynchronous active-low reset
//   in_valid / in_ready : raw-result handshake (ready only while idle)
//   in_sign, in_exp     : sign and biased exponent (0 is treated as 1)
//   in_mant             : {carry, hidden, frac[9:0], G, R, S}
//   out_valid/out_ready : result handshake
//   result              : packed fp16_t
module fpu_add_sub_normalizer
  import fpu_add_sub_normalizer_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [FP16_EXP_W-1:0] in_exp,
  input  logic [RAW_MANT_W-1:0] in_mant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           result
);

  // One extra exponent bit so carry/round increments past 31 are visible.
  localparam int unsigned WEXP_W = FP16_EXP_W + 1;

  norm_state_e             state_q, state_d;
  logic                    sign_q, sign_d;
  logic [WEXP_W-1:0]       exp_q, exp_d;
  logic [RAW_MANT_W-1:0]   mant_q, mant_d;
  logic [3:0]              shift_cnt_q, shift_cnt_d;
  fp16_t                   result_q, result_d;

  logic [FP16_FRAC_W:0]    rnd_mant;
  logic                    rnd_carry;
  logic                    rnd_hidden;
  logic [WEXP_W-1:0]       rnd_exp;
  fp16_t                   packed_res;

  fpuRounder u_rounder (
    .mant_in  (mant_q[RAW_MANT_W-2:3]),
    .grs      (mant_q[2:0]),
    .mant_out (rnd_mant),
    .carry    (rnd_carry)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      shift_cnt_q <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      shift_cnt_q <= shift_cnt_d;
      result_q    <= result_d;
    end
  end

  // Rounding carry past the hidden bit renormalizes to 1.0 at exp+1 (the
  // rounder wraps its fraction to zero). A subnormal that rounds into the
  // hidden bit becomes normal at the exponent it already holds (1).
  always_comb begin
    rnd_hidden = rnd_carry | rnd_mant[FP16_FRAC_W];
    rnd_exp    = exp_q + {{(WEXP_W-1){1'b0}}, rnd_carry};
    packed_res = '0;
    packed_res.sign = sign_q;
    if (mant_q == '0) begin
      packed_res.exp  = '0;
      packed_res.frac = '0;
    end else if (!rnd_hidden) begin
      packed_res.exp  = '0;
      packed_res.frac = rnd_mant[FP16_FRAC_W-1:0];
    end else if (rnd_exp >= {1'b0, EXP_MAX}) begin
      packed_res.exp  = EXP_MAX;
      packed_res.frac = '0;
    end else begin
      packed_res.exp  = rnd_exp[FP16_EXP_W-1:0];
      packed_res.frac = rnd_mant[FP16_FRAC_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    shift_cnt_d = shift_cnt_q;
    result_d    = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d      = in_sign;
          exp_d       = (in_exp == '0) ? WEXP_W'(1) : {1'b0, in_exp};
          mant_d      = in_mant;
          shift_cnt_d = '0;
          state_d     = S_NORM;
        end
      end
      S_NORM: begin
        if (mant_q[RAW_MANT_W-1]) begin
          // Bit shifted out of position 0 folds into sticky.
          mant_d  = {1'b0, mant_q[RAW_MANT_W-1:2], mant_q[1] | mant_q[0]};
          exp_d   = exp_q + WEXP_W'(1);
          state_d = S_ROUND;
        end else if (mant_q == '0) begin
          state_d = S_ROUND;
        end else if (mant_q[RAW_MANT_W-2] || exp_q == WEXP_W'(1) ||
                     shift_cnt_q == 4'(MAX_LSHIFT)) begin
          state_d = S_ROUND;
        end else begin
          mant_d      = {mant_q[RAW_MANT_W-2:0], 1'b0};
          exp_d       = exp_q - WEXP_W'(1);
          shift_cnt_d = shift_cnt_q + 4'd1;
        end
      end
      S_ROUND: begin
        result_d = packed_res;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_fpu_add_sub_normalizer.sv
module tb_fpu_add_sub_normalizer;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [14:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  fpu_add_sub_normalizer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle. Pushes the expectation,
  // presents one operation, waits (bounded) for out_valid, pops and compares,
  // optionally stalls the consumer while poking in_valid, then acknowledges.
  task automatic run_op(input string tag, input logic s, input logic [4:0] e,
                        input logic [14:0] m, input logic [15:0] res,
                        input int lat, input int stall);
    exp_t ex;
    int   cyc;
    sb_q.push_back('{tag, res, lat});
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    ex = sb_q.pop_front();
    chk({ex.tag, ".result"}, {16'd0, result}, {16'd0, ex.res});
    chk({ex.tag, ".latency"}, cyc, ex.lat);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_exp   = 5'd30;
      in_mant  = 15'h7FF8;
      @(posedge clock); #1;
      chk({tag, ".stall_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".stall_result"}, {16'd0, result}, {16'd0, ex.res});
      chk({tag, ".stall_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk({tag, ".ack_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".ack_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.result", {16'd0, result}, 32'd0);
    reset_n = 1'b1;

    // First edge after release accepts; out_ready while idle does nothing.
    out_ready = 1'b1;
    run_op("carry", 1'b0, 5'd15, 15'h4000, 16'h4000, 3, 0);
    chk("idle_out_ready.in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;

    run_op("cancel", 1'b0, 5'd15, 15'h0008, 16'h1400, 13, 0);
    run_op("subnormal_floor", 1'b0, 5'd2, 15'h0400, 16'h0100, 4, 0);
`ifdef FPU_NORM_ROUND_EN
    run_op("round_tie", 1'b0, 5'd15, 15'h3FFC, 16'h4000, 3, 0);
    run_op("round_up", 1'b0, 5'd15, 15'h2006, 16'h3C01, 3, 0);
`else
    run_op("round_tie", 1'b0, 5'd15, 15'h3FFC, 16'h3FFF, 3, 0);
    run_op("round_up", 1'b0, 5'd15, 15'h2006, 16'h3C00, 3, 0);
`endif
    run_op("overflow", 1'b0, 5'd30, 15'h7FF8, 16'h7C00, 3, 0);
    run_op("zero", 1'b1, 5'd15, 15'h0000, 16'h8000, 3, 0);
    run_op("exp_zero_as_one", 1'b1, 5'd0, 15'h1000, 16'h8200, 3, 0);
    run_op("shift_limit", 1'b0, 5'd20, 15'h0001, 16'h0100, 14, 0);
    run_op("stall", 1'b1, 5'd15, 15'h4000, 16'hC000, 3, 5);

    // Nothing captured during the stall may surface afterwards.
    repeat (4) begin
      @(posedge clock); #1;
      chk("no_ghost.out_valid", {31'd0, out_valid}, 32'd0);
    end

    // Reset in the middle of a long normalization.
    in_sign  = 1'b0;
    in_exp   = 5'd15;
    in_mant  = 15'h0008;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("mid_norm.busy", {31'd0, in_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_norm_reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_norm_reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_norm_reset.result", {16'd0, result}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    run_op("after_reset", 1'b0, 5'd15, 15'h4000, 16'h4000, 3, 0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
